// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment display driver.
package seg_pkg;

    // All segments dark (active-low encoding).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-high {g,f,e,d,c,b,a} patterns; element [n] is the glyph for hex value n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    // Phase within one digit slot.
    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high 7-segment pattern lookup.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_on
);

    assign seg_on = SEG_LUT[hex];

endmodule

// File: rtl/seg_scan_mux.sv
// Double-buffered, time-multiplexed driver for a common-anode 7-segment display.
// Producers write a shadow frame; it is committed to the active frame only at the
// frame boundary so a digit update never tears mid-scan. Each digit slot starts
// with a dead-time blank to suppress ghosting. All outputs come straight from flops.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [4*NDIG-1:0] digits_in,
    input  logic [NDIG-1:0]   dp_in,
    input  logic [NDIG-1:0]   blank_in,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [NDIG-1:0]   an,
    output logic              frame_done
);

    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = $clog2(NDIG);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NDIG - 1);

    logic [SLOT_W-1:0] slot_cnt, slot_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic              slot_wrap;
    logic              commit;

    logic [4*NDIG-1:0] sh_dig, act_dig, act_dig_nxt;
    logic [NDIG-1:0]   sh_dp, act_dp, act_dp_nxt;
    logic [NDIG-1:0]   sh_blank, act_blank, act_blank_nxt;

    logic [3:0]        cur_hex;
    logic [6:0]        cur_seg_on;
    scan_state_e       state_nxt;
    logic [6:0]        seg_nxt;
    logic              dp_nxt;
    logic [NDIG-1:0]   an_nxt;

    // The registered outputs are computed from the *next* counter and frame values,
    // so the output flops line up with slot_cnt/idx on the same cycle rather than
    // trailing them by one.
    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign commit    = slot_wrap && (idx == IDX_LAST);
    assign slot_nxt  = slot_wrap ? '0 : slot_cnt + 1'b1;
    assign idx_nxt   = !slot_wrap        ? idx :
                       (idx == IDX_LAST) ? '0  : idx + 1'b1;

    // A commit edge samples the shadow as it was before that edge, so a same-cycle
    // load lands in the shadow and waits for the following frame.
    assign act_dig_nxt   = commit ? sh_dig   : act_dig;
    assign act_dp_nxt    = commit ? sh_dp    : act_dp;
    assign act_blank_nxt = commit ? sh_blank : act_blank;

    assign cur_hex = act_dig_nxt[{idx_nxt, 2'b00} +: 4];

    seg_hex_decode u_decode (
        .hex    (cur_hex),
        .seg_on (cur_seg_on)
    );

    // Slot phase and next output levels for the upcoming cycle.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_nxt = BLANK;
        seg_nxt   = SEG_OFF;
        dp_nxt    = 1'b1;
        an_nxt    = '1;
        if ((int'(slot_nxt) >= BLANK_CYC) && !act_blank_nxt[idx_nxt]) begin
            state_nxt = SHOW;
        end
        if (state_nxt == SHOW) begin
            seg_nxt = ~cur_seg_on;
            dp_nxt  = ~act_dp_nxt[idx_nxt];
            an_nxt  = ~(NDIG'(1) << idx_nxt);
        end
    end

    // Slot and digit scan counters.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else begin
            slot_cnt <= slot_nxt;
            idx      <= idx_nxt;
        end
    end

    // Shadow frame: the last load before a commit wins.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these frame buffers are reset on purpose: a reset must discard any
        // pending frame and display zeros, not leftover data.
        if (!rst_n) begin
            sh_dig   <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
        end else if (load) begin
            sh_dig   <= digits_in;
            sh_dp    <= dp_in;
            sh_blank <= blank_in;
        end
    end

    // Active frame: updated from the shadow only at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_dig   <= '0;
            act_dp    <= '0;
            act_blank <= '0;
        end else begin
            act_dig   <= act_dig_nxt;
            act_dp    <= act_dp_nxt;
            act_blank <= act_blank_nxt;
        end
    end

    // Output flops; frame_done marks the first cycle of a newly committed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            an         <= an_nxt;
            frame_done <= commit;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with NDIG=4, REFRESH_DIV=8, BLANK_CYC=2.
// A frame is 32 cycles; within a slot, slot_cnt 0..1 is blank, 2..7 shows the digit.
module tb_seg_scan_mux;

    localparam int NDIG = 4;

    logic              clk;
    logic              rst_n;
    logic              load;
    logic [4*NDIG-1:0] digits_in;
    logic [NDIG-1:0]   dp_in;
    logic [NDIG-1:0]   blank_in;
    logic [6:0]        seg;
    logic              dp;
    logic [NDIG-1:0]   an;
    logic              frame_done;

    int pass_cnt  = 0;
    int check_cnt = 0;

    seg_scan_mux #(
        .NDIG        (NDIG),
        .REFRESH_DIV (8),
        .BLANK_CYC   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; land on the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until frame_done is seen (bounded); n returns the number of steps taken.
    task automatic wait_fd(input string name, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (!found && n < 100) begin
            step();
            n++;
            if (frame_done === 1'b1) found = 1'b1;
        end
        check_cnt++;
        if (!found) $display("FAIL %s: frame_done not seen within %0d cycles", name, n);
        else pass_cnt++;
    endtask

    task automatic load_frame(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        digits_in = d;
        dp_in     = p;
        blank_in  = b;
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load = 1'b0;
        digits_in = '0;
        dp_in = '0;
        blank_in = '0;
        step_n(3);
        check_cnt++;
        if ({seg, dp, an, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0})
            $display("FAIL reset_vals: seg=%h dp=%b an=%h fd=%b want seg=7f dp=1 an=f fd=0",
                     seg, dp, an, frame_done);
        else pass_cnt++;
        rst_n = 1'b1;                           // released on a falling edge: slot 0 now
        check_cnt++;
        if (an !== 4'hF) $display("FAIL reset_blank0: an=%h want f", an);
        else pass_cnt++;
        step();                                 // slot 1
        check_cnt++;
        if (an !== 4'hF) $display("FAIL reset_blank1: an=%h want f", an);
        else pass_cnt++;
        step();                                 // slot 2, digit 0 shows 0
        check_cnt++;
        if ({an, seg, dp} !== {4'hE, 7'h40, 1'b1})
            $display("FAIL reset_show0: an=%h seg=%h dp=%b want an=e seg=40 dp=1", an, seg, dp);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int n;
        load_frame(16'h4321, 4'b0100, 4'b0000);
        wait_fd("basic_fd", n);
        check_cnt++;
        if (an !== 4'hF) $display("FAIL basic_fd_blank: an=%h want f", an);
        else pass_cnt++;
        step();
        check_cnt++;
        if (frame_done !== 1'b0) $display("FAIL basic_fd_pulse: frame_done=%b want 0", frame_done);
        else pass_cnt++;
        step();                                 // idx0 slot2
        check_cnt++;
        if ({an, seg, dp} !== {4'hE, 7'h79, 1'b1})
            $display("FAIL basic_dig0: an=%h seg=%h dp=%b want an=e seg=79 dp=1", an, seg, dp);
        else pass_cnt++;
        step_n(8);                              // idx1 slot2
        check_cnt++;
        if ({an, seg} !== {4'hD, 7'h24})
            $display("FAIL basic_dig1: an=%h seg=%h want an=d seg=24", an, seg);
        else pass_cnt++;
        step_n(8);                              // idx2 slot2
        check_cnt++;
        if ({an, seg, dp} !== {4'hB, 7'h30, 1'b0})
            $display("FAIL basic_dig2: an=%h seg=%h dp=%b want an=b seg=30 dp=0", an, seg, dp);
        else pass_cnt++;
        wait_fd("basic_fd2", n);
        wait_fd("basic_fd3", n);
        check_cnt++;
        if (n !== 32) $display("FAIL basic_period: frame_done period=%0d want 32", n);
        else pass_cnt++;
    endtask

    // Starts on a frame_done cycle (cycle 0 of the frame).
    task automatic test_anti_tear();
        int n;
        int bad;
        load_frame(16'hAAAA, 4'b0000, 4'b0000);  // loaded at cycle 0
        step_n(4);                               // cycle 5
        load_frame(16'hBBBB, 4'b0000, 4'b0000);
        wait_fd("tear_fd", n);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (an !== 4'hF && seg !== 7'h03) bad++;
            step();
        end
        check_cnt++;
        if (bad != 0) $display("FAIL tear_only_b: %0d lit cycles not showing b (seg 03)", bad);
        else pass_cnt++;
        check_cnt++;
        if (frame_done !== 1'b1) $display("FAIL tear_frame_len: frame_done=%b want 1", frame_done);
        else pass_cnt++;
    endtask

    task automatic test_load_on_commit();
        int n;
        wait_fd("commit_sync", n);
        step_n(31);                              // idx3 slot7: next edge commits
        load_frame(16'h7777, 4'b0000, 4'b0000);
        check_cnt++;
        if (frame_done !== 1'b1) $display("FAIL commit_edge: frame_done=%b want 1", frame_done);
        else pass_cnt++;
        step_n(2);
        check_cnt++;
        if ({an, seg} !== {4'hE, 7'h03})
            $display("FAIL commit_old_kept: an=%h seg=%h want an=e seg=03", an, seg);
        else pass_cnt++;
        wait_fd("commit_fd", n);
        step_n(2);
        check_cnt++;
        if ({an, seg} !== {4'hE, 7'h78})
            $display("FAIL commit_new_shown: an=%h seg=%h want an=e seg=78", an, seg);
        else pass_cnt++;
    endtask

    task automatic test_blanking();
        int n;
        int c0, c1, c2, c3, bad;
        load_frame(16'h7777, 4'b0000, 4'b1010);
        wait_fd("blank_fd", n);
        c0 = 0; c1 = 0; c2 = 0; c3 = 0; bad = 0;
        for (int i = 0; i < 32; i++) begin
            case (an)
                4'hE: c0++;
                4'hD: c1++;
                4'hB: c2++;
                4'h7: c3++;
                4'hF: if (seg !== 7'h7F) bad++;
                default: bad++;
            endcase
            step();
        end
        check_cnt++;
        if (c0 != 6) $display("FAIL blank_dig0_lit: %0d cycles want 6", c0);
        else pass_cnt++;
        check_cnt++;
        if (c2 != 6) $display("FAIL blank_dig2_lit: %0d cycles want 6", c2);
        else pass_cnt++;
        check_cnt++;
        if (c1 != 0 || c3 != 0) $display("FAIL blank_dig13_dark: dig1=%0d dig3=%0d want 0 0", c1, c3);
        else pass_cnt++;
        check_cnt++;
        if (bad != 0) $display("FAIL blank_an_legal: %0d illegal cycles want 0", bad);
        else pass_cnt++;
    endtask

    // Starts on a frame_done cycle of the blank_in=1010 frame showing 7777.
    task automatic test_async_reset();
        int n;
        step_n(21);                              // idx2 slot5
        check_cnt++;
        if ({an, seg} !== {4'hB, 7'h78})
            $display("FAIL areset_pre: an=%h seg=%h want an=b seg=78", an, seg);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;                                      // still before the next rising edge
        check_cnt++;
        if ({seg, dp, an, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0})
            $display("FAIL areset_now: seg=%h dp=%b an=%h fd=%b want 7f 1 f 0", seg, dp, an, frame_done);
        else pass_cnt++;
        step_n(2);
        rst_n = 1'b1;
        step_n(2);
        check_cnt++;
        if ({an, seg} !== {4'hE, 7'h40})
            $display("FAIL areset_zero: an=%h seg=%h want an=e seg=40", an, seg);
        else pass_cnt++;
        wait_fd("areset_fd", n);
        step_n(10);                              // idx1 slot2, after a commit
        check_cnt++;
        if ({an, seg} !== {4'hD, 7'h40})
            $display("FAIL areset_shadow_cleared: an=%h seg=%h want an=d seg=40", an, seg);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_anti_tear();
        test_load_on_commit();
        test_blanking();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
